// File: rtl/sad_search_ctrl.sv
// -----------------------------------------------------------------------------
// sad_search_ctrl
//
// Sequences a SAD datapath over NUM_CAND candidate blocks. For each candidate
// it drives the address, waits out the SAD unit latency, samples the SAD and
// keeps the running minimum with its address. An optional early exit ends the
// search as soon as the best SAD found so far is at or below a threshold.
//
// Ports
//   clk         in   1         rising-edge clock
//   rst_n       in   1         asynchronous active-low reset
//   start       in   1         request a search (honoured only when idle)
//   thr_en      in   1         enable early exit (captured with start)
//   threshold   in   SAD_W     early-exit level (captured with start)
//   sad_addr    out  ADDR_W    candidate address to the SAD unit
//   sad_in      in   SAD_W     SAD returned by the SAD unit
//   busy        out  1         search in progress (ISSUE/WAIT/CMP)
//   done        out  1         one-cycle pulse, results valid
//   best_sad    out  SAD_W     minimum SAD of the last search
//   best_addr   out  ADDR_W    address of that minimum
//   cand_count  out  ADDR_W+1  candidates evaluated in the last search
//   early_exit  out  1         last search stopped on the threshold
// -----------------------------------------------------------------------------
module sad_search_ctrl #(
    parameter int ADDR_W      = 2,
    parameter int SAD_W       = 10,
    parameter int NUM_CAND    = 4,
    parameter int SAD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              thr_en,
    input  logic [SAD_W-1:0]  threshold,
    output logic [ADDR_W-1:0] sad_addr,
    input  logic [SAD_W-1:0]  sad_in,
    output logic              busy,
    output logic              done,
    output logic [SAD_W-1:0]  best_sad,
    output logic [ADDR_W-1:0] best_addr,
    output logic [ADDR_W:0]   cand_count,
    output logic              early_exit
);

    // The wait counter runs SAD_LATENCY-1 down to 0, one WAIT cycle per value.
    localparam int LAT_W = (SAD_LATENCY > 1) ? $clog2(SAD_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CAND - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(SAD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    state_t            state_q,      state_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [LAT_W-1:0]  lat_q,        lat_d;
    logic [SAD_W-1:0]  best_sad_q,   best_sad_d;
    logic [ADDR_W-1:0] best_addr_q,  best_addr_d;
    logic [ADDR_W:0]   cand_count_q, cand_count_d;
    logic              early_exit_q, early_exit_d;
    logic              thr_en_q,     thr_en_d;
    logic [SAD_W-1:0]  threshold_q,  threshold_d;
    logic              thr_hit;

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lat_d        = lat_q;
        best_sad_d   = best_sad_q;
        best_addr_d  = best_addr_q;
        cand_count_d = cand_count_q;
        early_exit_d = early_exit_q;
        thr_en_d     = thr_en_q;
        threshold_d  = threshold_q;
        thr_hit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    thr_en_d     = thr_en;
                    threshold_d  = threshold;
                    addr_d       = '0;
                    cand_count_d = '0;
                    early_exit_d = 1'b0;
                    state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                lat_d   = LAT_LOAD;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (lat_q == '0) begin
                    state_d = S_CMP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end

            S_CMP: begin
                cand_count_d = cand_count_q + 1'b1;
                // First candidate seeds the minimum; later ones must be strictly
                // smaller, so ties keep the lower address.
                if ((cand_count_q == '0) || (sad_in < best_sad_q)) begin
                    best_sad_d  = sad_in;
                    best_addr_d = addr_q;
                end
                // Threshold is tested against the updated minimum.
                thr_hit = thr_en_q && (best_sad_d <= threshold_q);
                if (thr_hit) begin
                    early_exit_d = 1'b1;
                end
                if (thr_hit || (addr_q == LAST_ADDR)) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, regardless of statement order.
    // NOTE: all control and result registers are reset because their values
    // are visible on outputs immediately after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            lat_q        <= '0;
            best_sad_q   <= '0;
            best_addr_q  <= '0;
            cand_count_q <= '0;
            early_exit_q <= 1'b0;
            thr_en_q     <= 1'b0;
            threshold_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lat_q        <= lat_d;
            best_sad_q   <= best_sad_d;
            best_addr_q  <= best_addr_d;
            cand_count_q <= cand_count_d;
            early_exit_q <= early_exit_d;
            thr_en_q     <= thr_en_d;
            threshold_q  <= threshold_d;
        end
    end

    assign sad_addr   = addr_q;
    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CMP);
    assign done       = (state_q == S_DONE);
    assign best_sad   = best_sad_q;
    assign best_addr  = best_addr_q;
    assign cand_count = cand_count_q;
    assign early_exit = early_exit_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sad_search_ctrl
//
// Scoreboard bench for sad_search_ctrl. A SAD-unit stub returns a table value
// for the driven address after SAD_LATENCY register stages. Each search pushes
// its expected result (from a plain loop over the table) into a queue; a
// monitor pops and compares on every done pulse, including done timing.
// -----------------------------------------------------------------------------
module tb_sad_search_ctrl;

    localparam int ADDR_W      = 2;
    localparam int SAD_W       = 10;
    localparam int NUM_CAND    = 4;
    localparam int SAD_LATENCY = 2;
    localparam int STEP        = SAD_LATENCY + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              thr_en = 1'b0;
    logic [SAD_W-1:0]  threshold = '0;
    logic [ADDR_W-1:0] sad_addr;
    logic [SAD_W-1:0]  sad_in;
    logic              busy;
    logic              done;
    logic [SAD_W-1:0]  best_sad;
    logic [ADDR_W-1:0] best_addr;
    logic [ADDR_W:0]   cand_count;
    logic              early_exit;

    sad_search_ctrl #(
        .ADDR_W(ADDR_W), .SAD_W(SAD_W), .NUM_CAND(NUM_CAND), .SAD_LATENCY(SAD_LATENCY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .thr_en(thr_en), .threshold(threshold),
        .sad_addr(sad_addr), .sad_in(sad_in), .busy(busy), .done(done),
        .best_sad(best_sad), .best_addr(best_addr), .cand_count(cand_count),
        .early_exit(early_exit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SAD unit stub: table lookup delayed by SAD_LATENCY register stages.
    logic [SAD_W-1:0] stub_mem [NUM_CAND];
    logic [SAD_W-1:0] pipe [SAD_LATENCY];
    always @(posedge clk) begin
        pipe[0] <= stub_mem[sad_addr];
        for (int i = 1; i < SAD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign sad_in = pipe[SAD_LATENCY-1];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int best_sad;
        int best_addr;
        int cnt;
        int early;
        int lat;
        int accept;
    } exp_t;

    exp_t sb_q[$];

    // Reference: scan the table in address order, keep a strict minimum,
    // stop after the first candidate whose running minimum meets the threshold.
    function automatic exp_t model(input bit te, input int thr);
        exp_t e;
        e.best_sad = 0; e.best_addr = 0; e.cnt = 0; e.early = 0;
        for (int a = 0; a < NUM_CAND; a++) begin
            if (a == 0 || int'(stub_mem[a]) < e.best_sad) begin
                e.best_sad  = int'(stub_mem[a]);
                e.best_addr = a;
            end
            e.cnt++;
            if (te && e.best_sad <= thr) begin
                e.early = 1;
                break;
            end
        end
        e.lat    = e.cnt * STEP;
        e.accept = 0;
        return e;
    endfunction

    // Search-progress monitor: busy and sad_addr during an active search.
    bit search_active = 0;
    int cur_accept = 0;
    int cur_n = 0;
    int mon_rel;
    always @(negedge clk) begin
        if (rst_n && search_active) begin
            mon_rel = cyc - cur_accept;
            if (mon_rel >= 0 && mon_rel < cur_n) begin
                check("busy_in_search", int'(busy), 1);
                check("sad_addr_seq", int'(sad_addr), mon_rel / STEP);
            end
        end
    end

    // Result monitor: one scoreboard entry per done pulse.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_latency", cyc - mon_e.accept, mon_e.lat);
                check("busy_at_done", int'(busy), 0);
                check("best_sad", int'(best_sad), mon_e.best_sad);
                check("best_addr", int'(best_addr), mon_e.best_addr);
                check("cand_count", int'(cand_count), mon_e.cnt);
                check("early_exit", int'(early_exit), mon_e.early);
            end
        end
    end

    task automatic set_mem(input int a0, input int a1, input int a2, input int a3);
        stub_mem[0] = SAD_W'(a0);
        stub_mem[1] = SAD_W'(a1);
        stub_mem[2] = SAD_W'(a2);
        stub_mem[3] = SAD_W'(a3);
    endtask

    // Runs one search from a negedge and returns at a negedge with start low.
    task automatic run_search(input bit te, input int thr, input bit pulse_busy,
                              input bit pulse_done);
        exp_t e;
        bit   got;
        e = model(te, thr);
        @(negedge clk);
        e.accept   = cyc + 1;
        cur_accept = e.accept;
        cur_n      = e.lat;
        sb_q.push_back(e);
        thr_en    = te;
        threshold = SAD_W'(thr);
        start     = 1'b1;
        search_active = 1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            // Input changes mid-search must have no effect.
            thr_en    = 1'($urandom);
            threshold = SAD_W'($urandom_range(0, 1023));
            if (done) begin
                got   = 1;
                start = pulse_done;
            end else begin
                start = pulse_busy && (i % 3 == 1);
            end
        end
        if (!got) check("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        search_active = 0;
        repeat (3) @(negedge clk);
        check("idle_after_done", int'(busy), 0);
        check("hold_best_sad", int'(best_sad), e.best_sad);
        check("hold_best_addr", int'(best_addr), e.best_addr);
        check("hold_cand_count", int'(cand_count), e.cnt);
    endtask

    initial begin
        set_mem(4, 5, 0, 1020);
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sad_addr", int'(sad_addr), 0);
        check("rst_best_sad", int'(best_sad), 0);
        check("rst_cand_count", int'(cand_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: full scan, early exits, ties, ignored starts.
        run_search(1'b0, 0, 1'b0, 1'b0);
        run_search(1'b1, 4, 1'b0, 1'b0);
        run_search(1'b1, 3, 1'b0, 1'b0);
        set_mem(7, 7, 7, 7);
        run_search(1'b0, 0, 1'b0, 1'b0);
        set_mem(4, 5, 0, 1020);
        run_search(1'b0, 0, 1'b1, 1'b1);

        // Async reset in the middle of WAIT.
        @(negedge clk);
        thr_en = 1'b0;
        start  = 1'b1;
        search_active = 1;
        cur_accept = cyc + 1;
        cur_n = NUM_CAND * STEP;
        sb_q.push_back('{0, 0, 0, 0, 0, 0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        search_active = 0;
        sb_q.delete();
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_sad_addr", int'(sad_addr), 0);
        check("arst_best_sad", int'(best_sad), 0);
        check("arst_best_addr", int'(best_addr), 0);
        check("arst_cand_count", int'(cand_count), 0);
        check("arst_early_exit", int'(early_exit), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_search(1'b0, 0, 1'b0, 1'b0);

        // Randomized searches; narrow value ranges make ties and hits likely.
        for (int n = 0; n < 40; n++) begin
            for (int a = 0; a < NUM_CAND; a++) begin
                stub_mem[a] = (n % 2 == 0) ? SAD_W'($urandom_range(0, 1020))
                                           : SAD_W'($urandom_range(0, 6));
            end
            run_search(1'($urandom), (n % 2 == 0) ? int'($urandom_range(0, 1023))
                                                  : int'($urandom_range(0, 6)),
                       1'($urandom), 1'($urandom));
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
